// File: rtl/serial_fifo_ctrl.sv
// rtl/serial_fifo_ctrl.sv - UART bridge with TX/RX FIFOs and strobe-sequencing FSM
//
// Purpose: buffers user words in a TX FIFO and writes them to a CPLD UART over a
// shared tri-state bus using the wrn strobe; reads received bytes with the rdn
// strobe into an RX FIFO presented show-ahead to the user.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   tx_valid/tx_data/tx_ready user TX handshake into the TX FIFO
//   rx_valid/rx_data/rx_ready user RX handshake out of the RX FIFO
//   tbre, tsre, data_ready    asynchronous UART status inputs
//   bus_data                  shared bidirectional UART data bus
//   rdn, wrn                  registered active-low UART strobes
//   ram_oe, ram_we, ram_en    SRAM disables, constant 1
//   tx_count, rx_count        FIFO occupancies
//   rx_overflow               sticky: data waited while RX FIFO was full
module serial_fifo_ctrl #(
    parameter int DW        = 8,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_valid,
    input  logic [DW-1:0]               tx_data,
    output logic                        tx_ready,
    output logic                        rx_valid,
    output logic [DW-1:0]               rx_data,
    input  logic                        rx_ready,
    input  logic                        tbre,
    input  logic                        tsre,
    input  logic                        data_ready,
    inout  wire  [DW-1:0]               bus_data,
    output logic                        rdn,
    output logic                        wrn,
    output logic                        ram_oe,
    output logic                        ram_we,
    output logic                        ram_en,
    output logic [$clog2(TX_DEPTH):0]   tx_count,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    output logic                        rx_overflow
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = $clog2(PULSE_CYC + 4);

    localparam logic [TAW:0]  TX_FULL    = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0]  RX_FULL    = (RAW+1)'(RX_DEPTH);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(3);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_SETUP = 3'd1;
    localparam logic [2:0] S_WR_PULSE = 3'd2;
    localparam logic [2:0] S_WR_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_PULSE = 3'd4;
    localparam logic [2:0] S_RD_HOLD  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          wrn_q, rdn_q, oe_q;
    logic [DW-1:0] bus_out_q;

    // Status synchronisers: bit 2 tbre, bit 1 tsre, bit 0 data_ready
    logic [2:0] meta_q, sync_q;
    logic       tbre_s, tsre_s, rdy_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {tbre, tsre, data_ready};
            sync_q <= meta_q;
        end
    end

    assign tbre_s = sync_q[2];
    assign tsre_s = sync_q[1];
    assign rdy_s  = sync_q[0];

    // TX FIFO
    logic [DW-1:0]  tx_mem_q [TX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_rp_q;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic           tx_push, tx_pop;

    assign tx_ready = (tx_cnt_q != TX_FULL);
    assign tx_push  = tx_valid & tx_ready;
    // The word leaves the FIFO only once its strobe has fully completed
    assign tx_pop   = (state_q == S_WR_PULSE) && (cnt_q == PULSE_LAST);
    assign tx_count = tx_cnt_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - (TAW+1)'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && tx_push) begin
            tx_mem_q[tx_wp_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + TAW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // RX FIFO
    logic [DW-1:0]  rx_mem_q [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_rp_q;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;
    logic           rx_push, rx_pop;

    assign rx_valid = (rx_cnt_q != '0);
    assign rx_pop   = rx_valid & rx_ready;
    // Bus is sampled on the last rdn-low cycle, at the edge that ends the strobe
    assign rx_push  = (state_q == S_RD_PULSE) && (cnt_q == PULSE_LAST);
    assign rx_data  = rx_mem_q[rx_rp_q];
    assign rx_count = rx_cnt_q;

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && rx_push) begin
            rx_mem_q[rx_wp_q] <= bus_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + RAW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + RAW'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Strobe sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Reads win: a waiting UART byte can be lost if left too long
                if (rdy_s && (rx_cnt_q == RX_FULL)) begin
                    ovf_d = 1'b1;
                end
                if (rdy_s && (rx_cnt_q != RX_FULL)) begin
                    state_d = S_RD_PULSE;
                end else if ((tx_cnt_q != '0) && tbre_s && tsre_s) begin
                    state_d = S_WR_SETUP;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = '0;
            end
            S_WR_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_WR_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_WAIT: begin
                // Synchronised tbre/tsre still show the pre-write state for a
                // few cycles; hold off before trusting them
                if (cnt_q != GUARD_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (tbre_s && tsre_s) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_RD_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD_HOLD: begin
                if (!rdy_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes and bus enable are registered from the next state so that they
    // line up exactly with the state they belong to
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wrn_q     <= 1'b1;
            rdn_q     <= 1'b1;
            oe_q      <= 1'b0;
            bus_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            wrn_q   <= (state_d != S_WR_PULSE);
            rdn_q   <= (state_d != S_RD_PULSE);
            oe_q    <= (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                       ((state_d == S_WR_WAIT) && (state_q == S_WR_PULSE));
            if ((state_q == S_IDLE) && (state_d == S_WR_SETUP)) begin
                bus_out_q <= tx_mem_q[tx_rp_q];
            end
        end
    end

    assign bus_data    = oe_q ? bus_out_q : {DW{1'bz}};
    assign wrn         = wrn_q;
    assign rdn         = rdn_q;
    assign rx_overflow = ovf_q;
    assign ram_oe      = 1'b1;
    assign ram_we      = 1'b1;
    assign ram_en      = 1'b1;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// tb/tb_serial_fifo_ctrl.sv - self-checking bench for serial_fifo_ctrl
module tb_serial_fifo_ctrl;

    localparam int TXD = 4;
    localparam int PC  = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tx_valid, rx_ready, tbre, tsre, data_ready;
    logic [7:0] tx_data, rx_data;
    logic       tx_ready, rx_valid, rdn, wrn, ram_oe, ram_we, ram_en, rx_overflow;
    logic [2:0] tx_count, rx_count;
    tri1  [7:0] bus_data;

    logic       uart_pend;
    logic [7:0] uart_byte;
    assign bus_data = (uart_pend && !rdn) ? uart_byte : 8'bz;

    serial_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tbre(tbre), .tsre(tsre), .data_ready(data_ready),
        .bus_data(bus_data), .rdn(rdn), .wrn(wrn),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_en(ram_en),
        .tx_count(tx_count), .rx_count(rx_count), .rx_overflow(rx_overflow)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        int         exp_count;
    } vec_t;
    vec_t vecs[6];

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] uart_q[$];

    int  wr_len, rd_len, wr_done, rd_done, wr_starts, cyc;
    int  first_wr, first_rd, rd_end;
    int  busy, gap, tbre_hi, k, w0, r0;
    bit  tx_auto, rx_auto, release_chk;
    logic [7:0] wr_word, prev_bus;
    logic       ew[6];
    logic [7:0] eb[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: account for handshakes, advance, then observe at the negedge
    task automatic step();
        bit         push_now, pop_now;
        logic [7:0] pd;
        push_now = tx_valid && tx_ready && rst;
        pop_now  = rx_valid && rx_ready && rst;
        pd       = tx_data;
        if (pop_now) begin
            if (exp_rx.size() == 0) chk("rx_pop_empty", 1, 0);
            else chk("rx_data", rx_data, exp_rx.pop_front());
        end
        prev_bus = bus_data;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (!rst) begin
            exp_tx.delete();
            exp_rx.delete();
            wr_len = 0;
            rd_len = 0;
            release_chk = 0;
        end else begin
            if (push_now) exp_tx.push_back(pd);
            if (release_chk) begin
                chk("bus_release", bus_data, 8'hFF);
                release_chk = 0;
            end
            if (!rdn || !wrn) chk("strobe_excl", rdn | wrn, 1);
            if (!wrn) begin
                if (wr_len == 0) begin
                    wr_starts++;
                    wr_word = bus_data;
                    chk("setup_bus", prev_bus, bus_data);
                    if (first_wr < 0) first_wr = cyc;
                    if (tx_auto) begin
                        chk("tbre_respected", tbre_hi >= 3, 1);
                        tbre = 0;
                        busy = $urandom_range(12, 6);
                    end
                end else begin
                    chk("wr_bus_hold", bus_data, wr_word);
                end
                wr_len++;
            end else if (wr_len != 0) begin
                chk("wrn_width", wr_len, PC);
                chk("wr_wait_bus", bus_data, wr_word);
                if (exp_tx.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_word", wr_word, exp_tx.pop_front());
                wr_done++;
                wr_len = 0;
                release_chk = 1;
            end
            if (!rdn) begin
                if (rd_len == 0 && first_rd < 0) first_rd = cyc;
                rd_len++;
            end else if (rd_len != 0) begin
                chk("rdn_width", rd_len, PC);
                if (uart_q.size() == 0) chk("rd_unexpected", 1, 0);
                else exp_rx.push_back(uart_q.pop_front());
                rd_done++;
                rd_end = cyc;
                rd_len = 0;
                gap = 4;
            end
            chk("tx_count", tx_count, exp_tx.size());
            chk("rx_count", rx_count, exp_rx.size());
            chk("rx_valid", rx_valid, exp_rx.size() != 0);
            chk("tx_ready", tx_ready, exp_tx.size() != TXD);
        end
        if (tx_auto && busy > 0) begin
            busy--;
            if (busy == 0) tbre = 1;
        end
        if (gap > 0) gap--;
        if (rx_auto) data_ready = (gap == 0) && (uart_q.size() != 0);
        uart_pend = (uart_q.size() != 0);
        uart_byte = uart_pend ? uart_q[0] : 8'h00;
        if (tbre) tbre_hi++;
        else tbre_hi = 0;
    endtask

    initial begin
        rst = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
        tbre = 1; tsre = 1; data_ready = 0;
        uart_pend = 0; uart_byte = 0;
        tx_auto = 0; rx_auto = 0; release_chk = 0;
        busy = 0; gap = 0; tbre_hi = 0; cyc = 0;
        wr_len = 0; rd_len = 0; wr_done = 0; rd_done = 0; wr_starts = 0;
        first_wr = -1; first_rd = -1; rd_end = -1;
        wr_word = 0; prev_bus = 0;

        // Reset state
        repeat (3) step();
        chk("ram_oe_rst", ram_oe, 1);
        chk("ram_we_rst", ram_we, 1);
        chk("ram_en_rst", ram_en, 1);
        chk("wrn_rst", wrn, 1);
        chk("rdn_rst", rdn, 1);
        chk("bus_rst", bus_data, 8'hFF);
        chk("tx_count_rst", tx_count, 0);
        chk("rx_valid_rst", rx_valid, 0);
        rst = 1;
        repeat (4) step();
        chk("ram_en_run", ram_en, 1);
        chk("ovf_rst", rx_overflow, 0);
        chk("tx_ready_rst", tx_ready, 1);

        // Single write of 0xA5, cycle by cycle
        ew = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        eb = '{8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hFF};
        tx_valid = 1; tx_data = 8'hA5;
        step();
        tx_valid = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("wr_seq_wrn%0d", i), wrn, ew[i]);
            chk($sformatf("wr_seq_bus%0d", i), bus_data, eb[i]);
            if (i < 5) step();
        end
        chk("wr_seq_count", tx_count, 0);
        repeat (6) step();

        // Single read of 0x3C, then hold while data_ready stays high
        uart_q.push_back(8'h3C);
        data_ready = 1;
        r0 = rd_done;
        k = 0;
        while (rd_done == r0 && k < 30) begin step(); k++; end
        chk("rd_done", rd_done - r0, 1);
        chk("rx_head_valid", rx_valid, 1);
        chk("rx_head_data", rx_data, 8'h3C);
        w0 = wr_starts;
        tx_valid = 1; tx_data = 8'h11;
        step();
        tx_valid = 0;
        repeat (8) step();
        chk("hold_no_write", wr_starts, w0);
        chk("hold_no_read", rd_done - r0, 1);
        data_ready = 0;
        w0 = wr_done;
        k = 0;
        while (wr_done == w0 && k < 30) begin step(); k++; end
        chk("write_after_hold", wr_done - w0, 1);
        rx_ready = 1; step(); rx_ready = 0;
        chk("ovf_clear", rx_overflow, 0);
        repeat (6) step();

        // Table: fill TX FIFO with UART busy
        tbre = 0;
        repeat (4) step();
        for (int i = 0; i < 6; i++) begin
            vecs[i].valid     = (i < 5);
            vecs[i].data      = 8'h40 + 8'(i * 17);
            vecs[i].exp_ready = (i < 4);
            vecs[i].exp_count = (i < 4) ? i + 1 : 4;
        end
        for (int i = 0; i < 6; i++) begin
            tx_valid = vecs[i].valid;
            tx_data  = vecs[i].data;
            chk($sformatf("tbl_ready%0d", i), tx_ready, vecs[i].exp_ready);
            step();
            chk($sformatf("tbl_count%0d", i), tx_count, vecs[i].exp_count);
        end
        tx_valid = 0;
        w0 = wr_done;
        tx_auto = 1; tbre = 1;
        k = 0;
        while (wr_done - w0 < 4 && k < 400) begin step(); k++; end
        chk("tbl_drained", wr_done - w0, 4);
        repeat (20) step();

        // Read and write eligible in the same IDLE evaluation
        tx_auto = 0; tbre = 0;
        repeat (4) step();
        tx_valid = 1; tx_data = 8'h77; step(); tx_valid = 0; step();
        first_wr = -1; first_rd = -1;
        w0 = wr_done; r0 = rd_done;
        rx_auto = 1; uart_q.push_back(8'h5A);
        data_ready = 1; tbre = 1; tx_auto = 1;
        k = 0;
        while ((wr_done == w0 || rd_done == r0) && k < 80) begin step(); k++; end
        chk("both_done", (wr_done - w0) + (rd_done - r0), 2);
        chk("rd_before_wr", (first_wr >= 0) && (rd_end < first_wr), 1);
        rx_ready = 1; repeat (3) step(); rx_ready = 0;
        repeat (10) step();

        // RX FIFO full with a byte still pending
        r0 = rd_done;
        for (int i = 0; i < 5; i++) uart_q.push_back(8'hC0 + 8'(i));
        repeat (80) step();
        chk("full_reads", rd_done - r0, 4);
        chk("full_count", rx_count, 4);
        chk("full_ovf", rx_overflow, 1);
        chk("full_pending", uart_q.size(), 1);
        rx_ready = 1; step(); rx_ready = 0;
        repeat (40) step();
        chk("full_one_more", rd_done - r0, 5);
        chk("full_count2", rx_count, 4);
        chk("full_ovf_sticky", rx_overflow, 1);
        rx_ready = 1; repeat (6) step(); rx_ready = 0;

        // Randomised traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            tx_valid = $urandom_range(1, 0);
            tx_data  = 8'($urandom);
            rx_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(9, 0) == 0 && uart_q.size() < 3) uart_q.push_back(8'($urandom));
            step();
        end
        tx_valid = 0; rx_ready = 1;
        k = 0;
        while ((exp_tx.size() != 0 || uart_q.size() != 0 || exp_rx.size() != 0) && k < 1000) begin
            step(); k++;
        end
        chk("random_drain", (exp_tx.size() == 0) && (uart_q.size() == 0) && (exp_rx.size() == 0), 1);
        rx_ready = 0;
        repeat (20) step();

        // Reset during the second wrn-low cycle
        tx_auto = 0; rx_auto = 0; data_ready = 0; tbre = 1;
        repeat (6) step();
        tx_valid = 1; tx_data = 8'h81; step();
        tx_data = 8'h82; step();
        tx_valid = 0;
        k = 0;
        while (wrn && k < 20) begin step(); k++; end
        chk("rst_wrn_low1", wrn, 0);
        step();
        chk("rst_wrn_low2", wrn, 0);
        rst = 0;
        step();
        chk("rst_mid_wrn", wrn, 1);
        chk("rst_mid_rdn", rdn, 1);
        chk("rst_mid_count", tx_count, 0);
        chk("rst_mid_bus", bus_data, 8'hFF);
        chk("rst_mid_ovf", rx_overflow, 0);
        chk("rst_mid_ram", {ram_oe, ram_we, ram_en}, 3'b111);
        rst = 1;
        w0 = wr_starts; r0 = rd_done;
        repeat (20) step();
        chk("rst_no_strobe", wr_starts - w0, 0);
        chk("rst_no_read", rd_done - r0, 0);
        chk("rst_tx_ready", tx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
